// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan feeder:
// blank code, slot state encoding and the leading-zero blank mask.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic {
    SHOW = 1'b0,
    DEAD = 1'b1
  } slot_state_t;

  // Bit i is set when digit i and every digit above it are zero.
  // Bit 0 is never set, so an all-zero value still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
    input logic [4*MAX_DIGITS-1:0] shadow,
    input int                      num_digits
  );
    logic run_zero;
    run_zero      = 1'b1;
    lz_blank_mask = '0;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < num_digits) begin
        run_zero         = run_zero & (shadow[4*i +: 4] == 4'h0);
        lz_blank_mask[i] = run_zero;
      end
    end
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot sequencer: counts lit and dead-time cycles per digit and steps
// the digit index 0..NUM_DIGITS-1 in a repeating scan.
//
// state | meaning
// SHOW  | digit digit_idx is lit for REFRESH_DIV cycles
// DEAD  | all anodes off for DEAD_CYCLES cycles, then advance digit
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output slot_state_t                   state,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam bit               HAS_DEAD  = (DEAD_CYCLES > 0);

  slot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (HAS_DEAD) begin
            state_d = DEAD;
          end else begin
            idx_d = idx_next;
          end
        end
      end
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_next;
          state_d = SHOW;
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign state     = state_q;
  assign digit_idx = idx_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Shadow-registered multi-digit BCD value time-multiplexed onto one shared
// active-low 7-segment decoder, with dead time and leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          blank_lz,
  output logic [3:0]                    data_out,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

  slot_state_t             slot_state;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              sel_code;
  logic                    sel_dp;
  logic                    sel_blank;

  seg_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .state     (slot_state),
    .digit_idx (idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
    end else begin
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
    end
  end

  always_comb begin
    shadow_digits_d = load ? digits_in : shadow_digits_q;
    shadow_dp_d     = load ? dp_in     : shadow_dp_q;
  end

  // Select the current digit's code, dp and blank flag from the shadow.
  always_comb begin
    lz_mask   = NUM_DIGITS'(lz_blank_mask((4*MAX_DIGITS)'(shadow_digits_q), NUM_DIGITS));
    an_sel    = '1;
    sel_code  = BLANK_CODE;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        an_sel[i] = 1'b0;
        sel_code  = shadow_digits_q[4*i +: 4];
        sel_dp    = shadow_dp_q[i];
        sel_blank = lz_mask[i];
      end
    end
  end

  // rst gates the outputs directly so the display goes dark the moment it rises.
  always_comb begin
    an       = '1;
    data_out = BLANK_CODE;
    dp       = 1'b1;
    if (!rst && slot_state == SHOW) begin
      an       = an_sel;
      data_out = (blank_lz && sel_blank) ? BLANK_CODE : sel_code;
      dp       = ~sel_dp;
    end
  end

  assign digit_idx = idx;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Upstream feeder for the 4-bit-in, active-low 7-segment digit decoder. It holds a multi-digit BCD value in a shadow register and time-multiplexes it onto one shared decoder. Each refresh slot presents one digit code and drives the matching active-low anode, with a dead-time gap between slots to prevent ghosting. Optional leading-zero blanking works by presenting code 4'hF, which the decoder renders as all segments off.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 100000, clock cycles each digit is lit (>=2)
DEAD_CYCLES, 2, clock cycles with all anodes off between digits (0 = no gap)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
digits_in  input  4*NUM_DIGITS  BCD digits; [3:0] is least significant digit 0
load  input  1  single-cycle strobe; captures digits_in and dp_in into the shadow register
dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high
blank_lz  input  1  leading-zero blanking enable (live input, not shadowed)
data_out  output  4  digit code to the decoder data input
an  output  NUM_DIGITS  anode enables, active-low, one-hot-low or all high
dp  output  1  decimal point, active-low
digit_idx  output  $clog2(NUM_DIGITS)  index of the current or next-lit digit

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high. All state clears immediately on rst assertion.
- Reset values:
  - shadow digits = 0, shadow dp = 0, cnt = 0, state = SHOW, digit_idx = 0.
  - Outputs while rst is high: an = all 1, data_out = 4'hF, dp = 1.
- Output timing: outputs are decoded only from registers (state, cnt, digit_idx, shadow) and from blank_lz. There is no path from digits_in, dp_in or load to the outputs within the same cycle.
- Shadow register: when load = 1 at a rising edge, the shadow takes digits_in and dp_in.
  - The new values appear on data_out and dp in the next cycle, even mid-slot.
  - The slot counter is not disturbed by load.
- State machine: SHOW and DEAD.
  - SHOW:
    - an = all 1 except bit digit_idx = 0.
    - data_out = shadow digit[digit_idx], or 4'hF if that digit is blanked.
    - dp = ~shadow_dp[digit_idx].
    - cnt increments each cycle. At cnt == REFRESH_DIV-1: cnt <= 0, and the next state is DEAD if DEAD_CYCLES > 0, otherwise SHOW with digit_idx advanced.
  - DEAD:
    - an = all 1, data_out = 4'hF, dp = 1.
    - At cnt == DEAD_CYCLES-1: cnt <= 0, digit_idx advances, next state = SHOW.
- Advance rule: digit_idx wraps from NUM_DIGITS-1 to 0. The scan order is 0,1,...,NUM_DIGITS-1,0,...
- Period: one full scan = NUM_DIGITS*(REFRESH_DIV+DEAD_CYCLES) cycles.
- Leading-zero blanking: digit i (i > 0) is blanked when blank_lz = 1 and every shadow digit from NUM_DIGITS-1 down to i equals 0.
  - Digit 0 is never blanked, so a value of zero shows as a single "0".
  - A blanked digit still drives its anode low, and its dp still follows shadow_dp.
- Non-BCD codes: digit codes 10..15 pass through unchanged. The decoder blanks them. No range checking is done here.
- Reset mid-slot: reset immediately forces the reset values. The scan restarts at digit 0, SHOW, cnt = 0 once rst is released.
- Counter width: cnt is $clog2(max(REFRESH_DIV, DEAD_CYCLES)) bits wide and must not overflow.

Decomposition:
- Shared package seg_pkg holds:
  - BLANK_CODE = 4'hF
  - the state enum {SHOW, DEAD}
  - a function returning the leading-zero blank mask for a shadow vector.
- One natural sub-module, seg_slot_timer: the cnt/state/digit_idx sequencer, parameterised by REFRESH_DIV, DEAD_CYCLES and NUM_DIGITS.
- seg_scan_mux instantiates seg_slot_timer and adds the shadow register and output decode.

Test Plan:
(Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.)
1. Reset: assert rst mid-run -> same cycle an=4'b1111, data_out=4'hF, dp=1. After release, an=4'b1110 for 4 cycles, then 1 cycle of 4'b1111, then 4'b1101.
2. Scan order: load digits_in=16'h1234, blank_lz=0 -> data_out sequence is 4,F,3,F,2,F,1,F, with an 1110,1111,1101,1111,1011,1111,0111,1111. Period is 20 cycles.
3. Leading zeros: load 16'h0050, blank_lz=1 -> digit3 and digit2 show F, digit1 shows 5, digit0 shows 0. Load 16'h0000 -> only digit0 shows 0.
4. Load mid-slot: during digit1 SHOW cycle 2, load 16'h9999 -> data_out=9 from the next cycle. Slot length is unchanged (dead time still at cycle 4).
5. Decimal point: dp_in=4'b0100 loaded -> dp=0 only while an=4'b1011; dp=1 during dead cycles.
6. DEAD_CYCLES=0 variant: an goes 1110→1101 with no all-high cycle; digit_idx wraps from 3 to 0.
